mmap_pingpong_writer: RTL and testbench
=======================================

# mmap_pingpong_writer

Parametrised successor to the single-buffer stream-to-BRAM writer in the mmap datapath. Beats from the rx stream go into two ping-pong banks of a true-dual-port BRAM through port B. A user interrupt fires for each bank as it fills. Backpressure or drop-with-count handles the case where software has not released a bank yet. Sits between the rx stream source and the BRAM whose port A is read by the PCIe DMA engine.

## Interface
- DATA_W, 64: stream/BRAM data width; multiple of 8.
- ADDR_W, 32: addrb width.
- BLOCK_WORDS, 512: words per bank; power of two, ≥4.
- BASE_ADDR, 0: byte address of bank 0 word 0.
- OVF_MODE, 0: 0 = backpressure via rx_tready; 1 = rx_tready tied high, beats into an unreleased bank are dropped and counted.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- rx_tvalid  in  1  beat valid.
- rx_tdata  in  DATA_W  beat data.
- rx_tready  out  1  beat accepted when rx_tvalid & rx_tready.
- usr_irq_req  out  2  per-vector interrupt request, level, held until acked.
- usr_irq_ack  in  2  one-cycle acknowledge per vector.
- msi_enable  in  1  MSI enabled by host.
- msi_vector_width  in  3  granted vectors, encoded as log2.
- clkb  out  1  equals clk.
- enb  out  1  BRAM port B enable.
- web  out  DATA_W/8  byte write enables, all ones when writing.
- addrb  out  ADDR_W  byte address.
- dinb  out  DATA_W  write data.
- ovf_cnt  out  16  saturating dropped-beat count (OVF_MODE=1 only).
- cur_bank  out  1  bank currently being filled.

## Operation
- State: cur (bank), wptr (log2 BLOCK_WORDS bits), pending[1:0], svc (oldest pending bank in legacy mode), ovf_cnt.
- Writer states: FILL when pending[cur]=0; BLOCKED when pending[cur]=1.
- Accept, in FILL:
  - Issue a write to {cur, wptr}.
  - addrb = BASE_ADDR + ({cur,wptr} × DATA_W/8), truncated to ADDR_W.
  - wptr increments.
  - On wptr = BLOCK_WORDS−1: wptr→0, pending[cur]→1, cur flips.
- BLOCKED, OVF_MODE=0: rx_tready=0.
- BLOCKED, OVF_MODE=1:
  - Valid beats are discarded: no write, wptr unchanged.
  - ovf_cnt increments and saturates at 0xFFFF.
- rx_tready = ~pending[cur] in mode 0; constant 1 in mode 1.
- Multi-vector mode is active when msi_enable=1 and msi_vector_width≥1:
  - usr_irq_req[b] = pending[b].
  - usr_irq_ack[b] while req[b]=1 clears pending[b].
- Legacy mode is active otherwise:
  - usr_irq_req[1]=0.
  - usr_irq_req[0] represents pending[svc].
  - usr_irq_ack[0] clears pending[svc] and flips svc.
  - If the other bank is also pending, req[0] deasserts for exactly one cycle, then reasserts.
- Acks with no matching req asserted are ignored.
- A mode change takes effect only when pending = 00.
- Simultaneous events:
  - The last beat of a bank and an ack of the other bank in the same cycle both take effect.
  - The next beat is then accepted without a stall.
  - An ack and a new pending on the same bank cannot coincide, because a bank cannot complete while it is pending.
- Reset: cur=0, wptr=0, pending=00, svc=0, ovf_cnt=0. Any in-flight write is cancelled.

## Timing
- Reset values:
  - enb=0, web=0, addrb=0, dinb=0, usr_irq_req=00, ovf_cnt=0, cur_bank=0.
  - rx_tready=1 in the cycle after reset deasserts.
- Write latency: the port B signals (enb, web, addrb, dinb) are registered and appear one cycle after the accepting edge. enb=web=0 otherwise.
- usr_irq_req is registered and rises in the same cycle as the bank's last write on port B.
- Ack at edge N:
  - req drops after edge N.
  - rx_tready (if blocked on that bank) rises after edge N.
  - The first resumed write appears on port B after edge N+1 at the earliest.
- Full throughput: one beat per cycle with no bubbles while acks arrive before the other bank fills.

## Test plan
- Flow with prompt acks (DATA_W=64, BLOCK_WORDS=16, BASE_ADDR=0, msi_enable=1, width=1):
  - Stimulus: 32 back-to-back beats.
  - Required: addrb 0x00…0xF8 step 8, dinb equals beats.
  - Required: usr_irq_req=01 with write 16; ack; usr_irq_req=10 with write 32.
- Backpressure (OVF_MODE=0, no acks):
  - Stimulus: 40 beats offered.
  - Required: exactly 32 accepted, then rx_tready=0.
  - Then ack[0]: rx_tready=1 next cycle, next write at addrb=0x00.
- Drop mode (OVF_MODE=1, no acks):
  - Stimulus: 40 beats.
  - Required: 32 writes, ovf_cnt=8, no enb for the dropped beats.
  - Then ack both: the next beat writes 0x00.
- Legacy mode (msi_enable=0):
  - Stimulus: 32 beats, no acks.
  - Required: req=01 only. ack[0] → req low for one cycle, then 01 again.
  - Required: second ack → 00. usr_irq_req[1] never asserts.
- Reset after 5 beats:
  - Required: enb=0, pending=00, ovf_cnt=0.
  - Required: the first beat after reset writes addrb=BASE_ADDR.
- Ack of bank 0 coincident with the last beat of bank 1 (bank 0 pending):
  - Required: usr_irq_req goes 01→10 in one step.
  - Required: the next beat writes 0x00 with no rx_tready deassertion.

Source files
------------

// File: rtl/mmap_pingpong_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mmap_pingpong_writer                                          |
// | Purpose  : Writes rx stream beats into two ping-pong banks of a BRAM     |
// |            through port B, raising one user interrupt per filled bank.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module mmap_pingpong_writer #(
   parameter int unsigned        DATA_W      = 64,
   parameter int unsigned        ADDR_W      = 32,
   parameter int unsigned        BLOCK_WORDS = 512,
   parameter logic [ADDR_W-1:0]  BASE_ADDR   = '0,
   parameter int unsigned        OVF_MODE    = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rx_tvalid,
   input  logic [DATA_W-1:0]     rx_tdata,
   output logic                  rx_tready,
   output logic [1:0]            usr_irq_req,
   input  logic [1:0]            usr_irq_ack,
   input  logic                  msi_enable,
   input  logic [2:0]            msi_vector_width,
   output logic                  clkb,
   output logic                  enb,
   output logic [DATA_W/8-1:0]   web,
   output logic [ADDR_W-1:0]     addrb,
   output logic [DATA_W-1:0]     dinb,
   output logic [15:0]           ovf_cnt,
   output logic                  cur_bank
);

   localparam int unsigned        c_BYTES = DATA_W / 8;
   localparam int unsigned        c_WP_W  = $clog2(BLOCK_WORDS);
   localparam logic [c_WP_W-1:0]  c_LAST  = c_WP_W'(BLOCK_WORDS - 1);

   // Writer state
   logic                  r_cur;
   logic [c_WP_W-1:0]     r_wptr;
   logic [1:0]            r_pending;
   logic                  r_multi;
   logic [15:0]           r_ovf_cnt;
   logic [1:0]            r_irq_req;

   // Port B pipeline registers
   logic                  r_enb;
   logic [c_BYTES-1:0]    r_web;
   logic [ADDR_W-1:0]     r_addrb;
   logic [DATA_W-1:0]     r_dinb;

   // Combinational decode
   logic                  w_blocked;
   logic                  w_acc;
   logic                  w_drop;
   logic                  w_last;
   logic                  w_multi;
   logic                  w_svc;
   logic                  w_svc_nxt;
   logic                  w_legacy_ack;
   logic [1:0]            w_clr;
   logic [1:0]            w_set;
   logic [1:0]            w_pend_nxt;
   logic                  w_cur_nxt;
   logic [1:0]            w_req_nxt;
   logic [c_WP_W:0]       w_word;
   logic [ADDR_W-1:0]     w_addr;

   assign w_blocked = r_pending[r_cur];
   assign w_acc     = rx_tvalid & ~w_blocked;
   assign w_drop    = (OVF_MODE != 0) & rx_tvalid & w_blocked;
   assign w_last    = w_acc & (r_wptr == c_LAST);

   // Interrupt mode may only switch while no bank is waiting for software.
   assign w_multi   = (r_pending == 2'b00) ? (msi_enable & (msi_vector_width != 3'd0))
                                           : r_multi;

   assign w_set      = w_last ? (2'b01 << r_cur) : 2'b00;
   assign w_pend_nxt = (r_pending & ~w_clr) | w_set;
   assign w_cur_nxt  = r_cur ^ w_last;

   assign w_word = {r_cur, r_wptr};
   assign w_addr = BASE_ADDR + (ADDR_W'(w_word) * ADDR_W'(c_BYTES));

   // Oldest pending bank: banks complete in order, so with both (or neither)
   // pending the oldest (or next to complete) is the one the writer points at.
   always_comb begin
      w_svc = r_cur;
      if (r_pending == 2'b01) begin
         w_svc = 1'b0;
      end else if (r_pending == 2'b10) begin
         w_svc = 1'b1;
      end
   end

   // Same derivation applied to the post-edge state, for the legacy request.
   always_comb begin
      w_svc_nxt = w_cur_nxt;
      if (w_pend_nxt == 2'b01) begin
         w_svc_nxt = 1'b0;
      end else if (w_pend_nxt == 2'b10) begin
         w_svc_nxt = 1'b1;
      end
   end

   // Acknowledge decode; an ack is only honoured while its request is high.
   always_comb begin
      w_clr        = 2'b00;
      w_legacy_ack = 1'b0;
      if (w_multi) begin
         w_clr = usr_irq_ack & r_irq_req;
      end else if (usr_irq_ack[0] & r_irq_req[0]) begin
         w_legacy_ack = 1'b1;
         w_clr        = 2'b01 << w_svc;
      end
   end

   // Request image; a legacy ack forces one low cycle so software sees a new edge.
   always_comb begin
      w_req_nxt = 2'b00;
      if (w_multi) begin
         w_req_nxt = w_pend_nxt;
      end else begin
         w_req_nxt[0] = ~w_legacy_ack & w_pend_nxt[w_svc_nxt];
      end
   end

   // Bank pointer, word pointer, pending flags and latched interrupt mode.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cur     <= 1'b0;
         r_wptr    <= '0;
         r_pending <= 2'b00;
         r_multi   <= 1'b0;
      end else begin
         r_cur     <= w_cur_nxt;
         r_pending <= w_pend_nxt;
         r_multi   <= w_multi;
         if (w_acc) begin
            r_wptr <= w_last ? '0 : r_wptr + 1'b1;
         end
      end
   end

   // Registered interrupt requests.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_irq_req <= 2'b00;
      end else begin
         r_irq_req <= w_req_nxt;
      end
   end

   // Saturating count of beats discarded into an unreleased bank.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ovf_cnt <= 16'd0;
      end else if (w_drop && (r_ovf_cnt != 16'hFFFF)) begin
         r_ovf_cnt <= r_ovf_cnt + 16'd1;
      end
   end

   // Port B write issued one cycle after the accepting edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_enb   <= 1'b0;
         r_web   <= '0;
         r_addrb <= '0;
         r_dinb  <= '0;
      end else begin
         r_enb <= w_acc;
         r_web <= {c_BYTES{w_acc}};
         if (w_acc) begin
            r_addrb <= w_addr;
            r_dinb  <= rx_tdata;
         end
      end
   end

   assign rx_tready   = (OVF_MODE != 0) ? 1'b1 : ~w_blocked;
   assign usr_irq_req = r_irq_req;
   assign clkb        = clk;
   assign enb         = r_enb;
   assign web         = r_web;
   assign addrb       = r_addrb;
   assign dinb        = r_dinb;
   assign ovf_cnt     = r_ovf_cnt;
   assign cur_bank    = r_cur;

endmodule
`default_nettype wire

// File: tb/tb_mmap_pingpong_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mmap_pingpong_writer                                       |
// | Purpose  : Self-checking bench; one backpressure and one drop-mode       |
// |            instance share the same stimulus.                             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_mmap_pingpong_writer;

   localparam int BW = 16;

   typedef struct {
      logic        vld;
      logic [63:0] data;
      logic [1:0]  ack;
      logic        msi;
      logic        acc_bp;
      logic        acc_dr;
      logic        rdy_bp;
      logic [1:0]  req;
      logic        cur;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        rx_tvalid;
   logic [63:0] rx_tdata;
   logic [1:0]  ack;
   logic        msi_enable;
   logic [2:0]  msi_w;

   logic        bp_rdy, dr_rdy, bp_clkb, dr_clkb, bp_enb, dr_enb, bp_cur, dr_cur;
   logic [1:0]  bp_req, dr_req;
   logic [7:0]  bp_web, dr_web;
   logic [31:0] bp_addrb, dr_addrb;
   logic [63:0] bp_dinb, dr_dinb;
   logic [15:0] bp_ovf, dr_ovf;

   int          n_checks = 0;
   int          n_errors = 0;
   int          idx_bp   = 0;
   int          idx_dr   = 0;
   logic [95:0] q_bp[$];
   logic [95:0] q_dr[$];
   vec_t        tbl[$];

   always #5 clk = ~clk;

   mmap_pingpong_writer #(
      .DATA_W(64), .ADDR_W(32), .BLOCK_WORDS(BW), .BASE_ADDR(32'h0), .OVF_MODE(0)
   ) u_bp (
      .clk(clk), .reset(rst), .rx_tvalid(rx_tvalid), .rx_tdata(rx_tdata),
      .rx_tready(bp_rdy), .usr_irq_req(bp_req), .usr_irq_ack(ack),
      .msi_enable(msi_enable), .msi_vector_width(msi_w), .clkb(bp_clkb),
      .enb(bp_enb), .web(bp_web), .addrb(bp_addrb), .dinb(bp_dinb),
      .ovf_cnt(bp_ovf), .cur_bank(bp_cur)
   );

   mmap_pingpong_writer #(
      .DATA_W(64), .ADDR_W(32), .BLOCK_WORDS(BW), .BASE_ADDR(32'h0), .OVF_MODE(1)
   ) u_dr (
      .clk(clk), .reset(rst), .rx_tvalid(rx_tvalid), .rx_tdata(rx_tdata),
      .rx_tready(dr_rdy), .usr_irq_req(dr_req), .usr_irq_ack(ack),
      .msi_enable(msi_enable), .msi_vector_width(msi_w), .clkb(dr_clkb),
      .enb(dr_enb), .web(dr_web), .addrb(dr_addrb), .dinb(dr_dinb),
      .ovf_cnt(dr_ovf), .cur_bank(dr_cur)
   );

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push_bp(input logic [63:0] d);
      q_bp.push_back({32'((idx_bp % (2 * BW)) * 8), d});
      idx_bp++;
   endtask

   task automatic push_dr(input logic [63:0] d);
      q_dr.push_back({32'((idx_dr % (2 * BW)) * 8), d});
      idx_dr++;
   endtask

   function automatic vec_t mk(input logic vld, input logic [63:0] d, input logic [1:0] a,
                               input logic msi, input logic acc_bp, input logic acc_dr,
                               input logic rdy, input logic [1:0] req, input logic cur);
      vec_t v;
      v.vld = vld; v.data = d; v.ack = a; v.msi = msi; v.acc_bp = acc_bp;
      v.acc_dr = acc_dr; v.rdy_bp = rdy; v.req = req; v.cur = cur;
      return v;
   endfunction

   // Port B scoreboards: every write must match the oldest expected beat.
   always @(negedge clk) begin
      logic [95:0] e;
      if (bp_enb === 1'b1) begin
         if (q_bp.size() == 0) begin
            chk("bp_unexpected_write", {32'h0, bp_addrb}, 96'hFFFF_FFFF);
         end else begin
            e = q_bp.pop_front();
            chk("bp_addrb", {64'h0, bp_addrb}, {64'h0, e[95:64]});
            chk("bp_dinb", {32'h0, bp_dinb}, {32'h0, e[63:0]});
            chk("bp_web", {88'h0, bp_web}, 96'hFF);
         end
      end else begin
         chk("bp_web_idle", {88'h0, bp_web}, 96'h0);
      end
      if (dr_enb === 1'b1) begin
         if (q_dr.size() == 0) begin
            chk("dr_unexpected_write", {32'h0, dr_addrb}, 96'hFFFF_FFFF);
         end else begin
            e = q_dr.pop_front();
            chk("dr_addrb", {64'h0, dr_addrb}, {64'h0, e[95:64]});
            chk("dr_dinb", {32'h0, dr_dinb}, {32'h0, e[63:0]});
            chk("dr_web", {88'h0, dr_web}, 96'hFF);
         end
      end else begin
         chk("dr_web_idle", {88'h0, dr_web}, 96'h0);
      end
   end

   task automatic run_tbl(input string tag);
      vec_t v;
      for (int k = 0; k < tbl.size(); k++) begin
         v          = tbl[k];
         rx_tvalid  = v.vld;
         rx_tdata   = v.data;
         ack        = v.ack;
         msi_enable = v.msi;
         if (v.acc_bp) push_bp(v.data);
         if (v.acc_dr) push_dr(v.data);
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("%s_bp_req[%0d]", tag, k), {94'h0, bp_req}, {94'h0, v.req});
         chk($sformatf("%s_dr_req[%0d]", tag, k), {94'h0, dr_req}, {94'h0, v.req});
         chk($sformatf("%s_bp_rdy[%0d]", tag, k), {95'h0, bp_rdy}, {95'h0, v.rdy_bp});
         chk($sformatf("%s_dr_rdy[%0d]", tag, k), {95'h0, dr_rdy}, 96'h1);
         chk($sformatf("%s_bp_cur[%0d]", tag, k), {95'h0, bp_cur}, {95'h0, v.cur});
         chk($sformatf("%s_dr_cur[%0d]", tag, k), {95'h0, dr_cur}, {95'h0, v.cur});
      end
      tbl.delete();
      rx_tvalid = 1'b0;
      ack       = 2'b00;
      #1;
      chk({tag, "_bp_sb_empty"}, 96'(q_bp.size()), 96'h0);
      chk({tag, "_dr_sb_empty"}, 96'(q_dr.size()), 96'h0);
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      rx_tvalid = 1'b0;
      ack       = 2'b00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst    = 1'b0;
      idx_bp = 0;
      idx_dr = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      logic [63:0] d;
      logic [1:0]  rq;
      logic        cu;
      rst = 1'b1; rx_tvalid = 1'b0; rx_tdata = '0; ack = 2'b00;
      msi_enable = 1'b1; msi_w = 3'd1;

      // Reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_bp_enb", {95'h0, bp_enb}, 96'h0);
      chk("rst_dr_enb", {95'h0, dr_enb}, 96'h0);
      chk("rst_bp_addrb", {64'h0, bp_addrb}, 96'h0);
      chk("rst_bp_dinb", {32'h0, bp_dinb}, 96'h0);
      chk("rst_bp_req", {94'h0, bp_req}, 96'h0);
      chk("rst_dr_req", {94'h0, dr_req}, 96'h0);
      chk("rst_dr_ovf", {80'h0, dr_ovf}, 96'h0);
      chk("rst_bp_cur", {95'h0, bp_cur}, 96'h0);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_bp_rdy", {95'h0, bp_rdy}, 96'h1);
      chk("rst_dr_rdy", {95'h0, dr_rdy}, 96'h1);

      // Flow with prompt acks
      for (int i = 0; i < 32; i++) begin
         d  = {$urandom, $urandom};
         rq = (i < 15) ? 2'b00 : (i == 15) ? 2'b01 : (i < 31) ? 2'b00 : 2'b10;
         cu = (i >= 15 && i < 31);
         tbl.push_back(mk(1'b1, d, (i == 16) ? 2'b01 : 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, rq, cu));
      end
      tbl.push_back(mk(1'b0, 64'h0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0));
      run_tbl("flow");

      // Backpressure / drop, no acks: 40 beats offered
      for (int i = 0; i < 40; i++) begin
         d  = {$urandom, $urandom};
         rq = (i < 15) ? 2'b00 : (i < 31) ? 2'b01 : 2'b11;
         cu = (i >= 15 && i < 31);
         tbl.push_back(mk(1'b1, d, 2'b00, 1'b1, i < 32, i < 32, i < 31, rq, cu));
      end
      tbl.push_back(mk(1'b0, 64'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0));
      run_tbl("bp");
      chk("bp_ovf_cnt", {80'h0, bp_ovf}, 96'h0);
      chk("dr_ovf_cnt", {80'h0, dr_ovf}, 96'd8);
      d = 64'hDEAD_BEEF_0000_0001;
      tbl.push_back(mk(1'b0, 64'h0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0));
      tbl.push_back(mk(1'b1, d, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0));
      run_tbl("resume");

      // Reset in the middle of a bank, with a beat on the reset edge
      for (int i = 0; i < 5; i++) begin
         d = {$urandom, $urandom};
         push_bp(d); push_dr(d);
         rx_tvalid = 1'b1; rx_tdata = d;
         @(posedge clk);
         @(negedge clk);
      end
      rx_tdata = 64'h1111_2222_3333_4444;
      rst      = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("mrst_bp_enb", {95'h0, bp_enb}, 96'h0);
      chk("mrst_dr_enb", {95'h0, dr_enb}, 96'h0);
      chk("mrst_dr_ovf", {80'h0, dr_ovf}, 96'h0);
      chk("mrst_bp_req", {94'h0, bp_req}, 96'h0);
      chk("mrst_dr_cur", {95'h0, dr_cur}, 96'h0);
      rst = 1'b0; rx_tvalid = 1'b0; idx_bp = 0; idx_dr = 0;
      @(posedge clk);
      @(negedge clk);
      chk("mrst_bp_rdy", {95'h0, bp_rdy}, 96'h1);
      d = 64'h5555_AAAA_0F0F_F0F0;
      tbl.push_back(mk(1'b1, d, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0));
      run_tbl("postrst");

      // Legacy interrupt mode; msi_enable rises while banks are pending
      do_reset();
      for (int i = 0; i < 32; i++) begin
         d  = {$urandom, $urandom};
         rq = (i < 15) ? 2'b00 : 2'b01;
         cu = (i >= 15 && i < 31);
         tbl.push_back(mk(1'b1, d, 2'b00, 1'b0, 1'b1, 1'b1, i < 31, rq, cu));
      end
      tbl.push_back(mk(1'b0, 64'h0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0));
      tbl.push_back(mk(1'b0, 64'h0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0));
      tbl.push_back(mk(1'b0, 64'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0));
      tbl.push_back(mk(1'b0, 64'h0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0));
      tbl.push_back(mk(1'b0, 64'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0));
      run_tbl("legacy");

      // Ack of bank 0 coincident with the last beat of bank 1
      do_reset();
      for (int i = 0; i < 33; i++) begin
         d  = {$urandom, $urandom};
         rq = (i < 15) ? 2'b00 : (i < 31) ? 2'b01 : 2'b10;
         cu = (i >= 15 && i < 31);
         tbl.push_back(mk(1'b1, d, (i == 31) ? 2'b01 : 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, rq, cu));
      end
      tbl.push_back(mk(1'b0, 64'h0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0));
      run_tbl("coinc");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
